// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo audio mixer.
// Holds the sample type, the mixer FSM encoding, the fixed-point
// widths used through the mix path and a 24-bit saturation helper.
package audio_pkg;

    localparam int ACC_W     = 26;  // four 24-bit samples summed without overflow
    localparam int SCL_W     = 29;  // accumulator times a gain of up to 8
    localparam int MIX_SHIFT = 5;

    typedef logic signed [23:0] sample_t;

    localparam sample_t SAMPLE_MAX = 24'sh7FFFFF;
    localparam sample_t SAMPLE_MIN = 24'sh800000;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SCALE,
        FILTER,
        OUTPUT
    } mixer_state_t;

    // Clamp a wide signed value into the 24-bit sample range. The value
    // fits when every bit from the sign down to bit 23 agrees.
    function automatic sample_t sat_sample(input logic signed [SCL_W-1:0] v);
        logic [SCL_W-24:0] hi;
        hi = v[SCL_W-1:23];
        if ((hi == '0) || (hi == '1)) begin
            return v[23:0];
        end else if (v[SCL_W-1]) begin
            return SAMPLE_MIN;
        end else begin
            return SAMPLE_MAX;
        end
    endfunction

endpackage

// File: rtl/mixer_scale_sat.sv
// Per-side output stage of the mixer: applies the master volume gain
// (vol+1, i.e. 1..8), divides by 32 with an arithmetic shift (floor
// toward minus infinity) and saturates to a 24-bit sample. Purely
// combinational; the mixer registers the result.
module mixer_scale_sat
    import audio_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic [2:0]              i_vol,
    output sample_t                 o_sample
);

    logic signed [SCL_W-1:0] w_acc_ext;
    logic signed [SCL_W-1:0] w_gain;
    logic signed [SCL_W-1:0] w_scaled;
    logic signed [SCL_W-1:0] w_shifted;

    assign w_acc_ext = {{(SCL_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
    assign w_gain    = $signed({{(SCL_W-4){1'b0}}, ({1'b0, i_vol} + 4'd1)});
    assign w_scaled  = w_acc_ext * w_gain;
    assign w_shifted = w_scaled >>> MIX_SHIFT;
    assign o_sample  = sat_sample(w_shifted);

endmodule

// File: rtl/audio_mixer.sv
// Stereo mixer for the 4-channel audio unit. On each sample_tick it
// snapshots the channel samples and NR50/NR51 (zeroing the samples when
// NR52[7] is clear), accumulates one channel per cycle into left/right
// sums according to the panning mask, scales/saturates each side and
// offers the pair downstream on a valid/ready handshake. A tick that
// cannot be taken sets the sticky overrun flag.
//
// Optional build macro: AUDIO_MIXER_DC_BLOCK_EN adds a FILTER state that
// runs a per-side DC-blocking high-pass on the scaled sample, adding one
// cycle of latency.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for sample_tick
// ACCUM  | adding channel r_idx (ch1..ch4) into the side accumulators
// SCALE  | volume, shift and saturation of both sides
// FILTER | DC-blocking high-pass (only with AUDIO_MIXER_DC_BLOCK_EN)
// OUTPUT | pair held on out_* until out_ready; a tick on the accepting
//        | edge starts the next mix directly
module audio_mixer
    import audio_pkg::*;
#(
    parameter int CH_W  = 24,
    parameter int OUT_W = 24
) (
    input  logic                    system_clock,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic signed [CH_W-1:0]  ch1_wave,
    input  logic signed [CH_W-1:0]  ch2_wave,
    input  logic signed [CH_W-1:0]  ch3_wave,
    input  logic signed [CH_W-1:0]  ch4_wave,
    input  logic [7:0]              NR50,
    input  logic [7:0]              NR51,
    input  logic [7:0]              NR52,
    output logic signed [OUT_W-1:0] out_left,
    output logic signed [OUT_W-1:0] out_right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    mixer_state_t r_state;
    mixer_state_t w_state_nxt;

    sample_t                 r_snap [4];
    logic [2:0]              r_vol_l;
    logic [2:0]              r_vol_r;
    logic [7:0]              r_pan;
    logic signed [ACC_W-1:0] r_acc_l;
    logic signed [ACC_W-1:0] r_acc_r;
    logic [1:0]              r_idx;
    sample_t                 r_out_l;
    sample_t                 r_out_r;
    logic                    r_valid;
    logic                    r_overrun;

    logic                    w_hs;
    logic                    w_snap;
    logic                    w_drop;
    sample_t                 w_cur;
    logic signed [ACC_W-1:0] w_cur_ext;
    sample_t                 w_scl_l;
    sample_t                 w_scl_r;
    logic                    w_unused;

    // Reserved register bits carry no function in the mixer.
    assign w_unused = ^{NR52[6:0], NR50[7], NR50[3]};

    assign w_hs      = (r_state == OUTPUT) && r_valid && out_ready;
    assign w_drop    = sample_tick && !w_snap;
    assign w_cur     = r_snap[r_idx];
    assign w_cur_ext = {{(ACC_W-24){w_cur[23]}}, w_cur};

    mixer_scale_sat u_scale_l (
        .i_acc    (r_acc_l),
        .i_vol    (r_vol_l),
        .o_sample (w_scl_l)
    );

    mixer_scale_sat u_scale_r (
        .i_acc    (r_acc_r),
        .i_vol    (r_vol_r),
        .o_sample (w_scl_r)
    );

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    sample_t r_x_l;
    sample_t r_x_r;
    sample_t r_xp_l;
    sample_t r_xp_r;
    sample_t r_yp_l;
    sample_t r_yp_r;
    sample_t w_flt_l;
    sample_t w_flt_r;

    // y = x - x_prev + y_prev - y_prev/256, evaluated at accumulator width.
    function automatic sample_t dc_block(input sample_t x, input sample_t xp, input sample_t yp);
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] xpe;
        logic signed [ACC_W-1:0] ype;
        logic signed [ACC_W-1:0] y;
        xe  = {{(ACC_W-24){x[23]}}, x};
        xpe = {{(ACC_W-24){xp[23]}}, xp};
        ype = {{(ACC_W-24){yp[23]}}, yp};
        y   = xe - xpe + ype - (ype >>> 8);
        return sat_sample({{(SCL_W-ACC_W){y[ACC_W-1]}}, y});
    endfunction

    assign w_flt_l = dc_block(r_x_l, r_xp_l, r_yp_l);
    assign w_flt_r = dc_block(r_x_r, r_xp_r, r_yp_r);
`endif

    // State register.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and snapshot strobe; a tick is only taken in IDLE or on
    // the edge that completes the output handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample_tick) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = SCALE;
                end
            end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            SCALE:  w_state_nxt = FILTER;
            FILTER: w_state_nxt = OUTPUT;
`else
            SCALE:  w_state_nxt = OUTPUT;
`endif
            OUTPUT: begin
                if (w_hs) begin
                    if (sample_tick) begin
                        w_snap      = 1'b1;
                        w_state_nxt = ACCUM;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Mix datapath: snapshot, accumulate, scale, optional filter, handshake.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= '0;
            end
            r_vol_l   <= '0;
            r_vol_r   <= '0;
            r_pan     <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_idx     <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            r_x_l     <= '0;
            r_x_r     <= '0;
            r_xp_l    <= '0;
            r_xp_r    <= '0;
            r_yp_l    <= '0;
            r_yp_r    <= '0;
`endif
        end else begin
            if (w_snap) begin
                r_snap[0] <= NR52[7] ? sample_t'(ch1_wave) : '0;
                r_snap[1] <= NR52[7] ? sample_t'(ch2_wave) : '0;
                r_snap[2] <= NR52[7] ? sample_t'(ch3_wave) : '0;
                r_snap[3] <= NR52[7] ? sample_t'(ch4_wave) : '0;
                r_vol_l   <= NR50[6:4];
                r_vol_r   <= NR50[2:0];
                r_pan     <= NR51;
                r_acc_l   <= '0;
                r_acc_r   <= '0;
                r_idx     <= '0;
            end
            if (r_state == ACCUM) begin
                r_acc_l <= r_acc_l + (r_pan[{1'b1, r_idx}] ? w_cur_ext : '0);
                r_acc_r <= r_acc_r + (r_pan[{1'b0, r_idx}] ? w_cur_ext : '0);
                r_idx   <= r_idx + 2'd1;
            end
            if (r_state == SCALE) begin
`ifdef AUDIO_MIXER_DC_BLOCK_EN
                r_x_l   <= w_scl_l;
                r_x_r   <= w_scl_r;
`else
                r_out_l <= w_scl_l;
                r_out_r <= w_scl_r;
                r_valid <= 1'b1;
`endif
            end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            if (r_state == FILTER) begin
                r_out_l <= w_flt_l;
                r_out_r <= w_flt_r;
                r_xp_l  <= r_x_l;
                r_xp_r  <= r_x_r;
                r_yp_l  <= w_flt_l;
                r_yp_r  <= w_flt_r;
                r_valid <= 1'b1;
            end
`endif
            if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_left  = r_out_l;
    assign out_right = r_out_r;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed self-checking bench for audio_mixer (default build).
module tb_audio_mixer;

    logic               system_clock = 1'b0;
    logic               reset;
    logic               sample_tick;
    logic signed [23:0] ch1_wave, ch2_wave, ch3_wave, ch4_wave;
    logic [7:0]         NR50, NR51, NR52;
    logic signed [23:0] out_left, out_right;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 system_clock = ~system_clock;

    audio_mixer #(.CH_W(24), .OUT_W(24)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .ch1_wave     (ch1_wave),
        .ch2_wave     (ch2_wave),
        .ch3_wave     (ch3_wave),
        .ch4_wave     (ch4_wave),
        .NR50         (NR50),
        .NR51         (NR51),
        .NR52         (NR52),
        .out_left     (out_left),
        .out_right    (out_right),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    task automatic set_chans(input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c, input logic [23:0] d);
        ch1_wave = a; ch2_wave = b; ch3_wave = c; ch4_wave = d;
    endtask

    task automatic set_regs(input logic [7:0] r50, input logic [7:0] r51, input logic [7:0] r52);
        NR50 = r50; NR51 = r51; NR52 = r52;
    endtask

    // Pulse one tick and return the number of edges (tick edge included)
    // until out_valid is seen high; bounded at 20.
    task automatic run_mix(output int lat);
        @(negedge system_clock);
        sample_tick = 1'b1;
        @(negedge system_clock);
        sample_tick = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge system_clock);
            lat++;
        end
    endtask

    // Count edges to out_valid after the tick edge has already passed.
    task automatic wait_valid(inout int lat);
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge system_clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; sample_tick = 1'b0; out_ready = 1'b1;
        set_chans(24'h0, 24'h0, 24'h0, 24'h0);
        set_regs(8'h77, 8'hFF, 8'h80);
        repeat (3) @(negedge system_clock);
        n_checks++; if (out_left  !== 24'sh0) $display("FAIL reset_left: got %h want 000000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh0) $display("FAIL reset_right: got %h want 000000", out_right); else n_pass++;
        n_checks++; if (out_valid !== 1'b0)   $display("FAIL reset_valid: got %b want 0", out_valid);      else n_pass++;
        n_checks++; if (overrun   !== 1'b0)   $display("FAIL reset_overrun: got %b want 0", overrun);      else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_unity;
        int lat;
        set_chans(24'h100000, 24'h100000, 24'h100000, 24'h100000);
        set_regs(8'h77, 8'hFF, 8'h80);
        run_mix(lat);
        n_checks++; if (lat != 6) $display("FAIL unity_latency: got %0d edges want 6", lat); else n_pass++;
        n_checks++; if (out_left  !== 24'sh100000) $display("FAIL unity_left: got %h want 100000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh100000) $display("FAIL unity_right: got %h want 100000", out_right); else n_pass++;
        @(negedge system_clock);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unity_pulse: got valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturate;
        int lat;
        set_chans(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        run_mix(lat);
        n_checks++; if (out_left  !== 24'sh7FFFFF) $display("FAIL max_left: got %h want 7fffff", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh7FFFFF) $display("FAIL max_right: got %h want 7fffff", out_right); else n_pass++;
        @(negedge system_clock);
        set_chans(24'h800000, 24'h800000, 24'h800000, 24'h800000);
        run_mix(lat);
        n_checks++; if (out_left  !== 24'sh800000) $display("FAIL min_left: got %h want 800000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh800000) $display("FAIL min_right: got %h want 800000", out_right); else n_pass++;
        @(negedge system_clock);
    endtask

    task automatic test_pan_volume;
        int lat;
        // ch1 to left only, left gain 4: 0x200000*4/32 = 0x040000.
        set_chans(24'h200000, 24'h0, 24'h0, 24'h0);
        set_regs(8'h30, 8'h10, 8'h80);
        run_mix(lat);
        n_checks++; if (out_left  !== 24'sh040000) $display("FAIL pan1_left: got %h want 040000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh000000) $display("FAIL pan1_right: got %h want 000000", out_right); else n_pass++;
        @(negedge system_clock);
        // L = ch1+ch3 = 0x40000, x2/32 = 0x4000; R = ch2+ch4 = 0x60000, x4/32 = 0xC000.
        set_chans(24'h080000, 24'h040000, 24'hFC0000, 24'h020000);
        set_regs(8'h13, 8'h5A, 8'h80);
        run_mix(lat);
        n_checks++; if (out_left  !== 24'sh004000) $display("FAIL pan2_left: got %h want 004000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh00C000) $display("FAIL pan2_right: got %h want 00c000", out_right); else n_pass++;
        @(negedge system_clock);
        // -1 * 1 >>> 5 floors to -1.
        set_chans(24'hFFFFFF, 24'h0, 24'h0, 24'h0);
        set_regs(8'h00, 8'h10, 8'h80);
        run_mix(lat);
        n_checks++; if (out_left !== 24'shFFFFFF) $display("FAIL neg_floor_left: got %h want ffffff", out_left); else n_pass++;
        @(negedge system_clock);
    endtask

    task automatic test_master_disable;
        int lat;
        set_chans(24'h100000, 24'h100000, 24'h100000, 24'h100000);
        set_regs(8'h77, 8'hFF, 8'h00);
        run_mix(lat);
        n_checks++; if (lat != 6) $display("FAIL mute_latency: got %0d edges want 6", lat); else n_pass++;
        n_checks++; if (out_left  !== 24'sh0) $display("FAIL mute_left: got %h want 000000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh0) $display("FAIL mute_right: got %h want 000000", out_right); else n_pass++;
        @(negedge system_clock);
        NR52 = 8'h80;
        run_mix(lat);
        n_checks++; if (out_left !== 24'sh100000) $display("FAIL unmute_left: got %h want 100000", out_left); else n_pass++;
        @(negedge system_clock);
    endtask

    task automatic test_midmix_write;
        int lat;
        set_chans(24'h100000, 24'h100000, 24'h100000, 24'h100000);
        set_regs(8'h77, 8'hFF, 8'h80);
        @(negedge system_clock);
        sample_tick = 1'b1;
        @(negedge system_clock);
        sample_tick = 1'b0;
        set_chans(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        set_regs(8'h00, 8'h00, 8'h00);
        lat = 1;
        wait_valid(lat);
        n_checks++; if (out_left  !== 24'sh100000) $display("FAIL midwrite_left: got %h want 100000", out_left);   else n_pass++;
        n_checks++; if (out_right !== 24'sh100000) $display("FAIL midwrite_right: got %h want 100000", out_right); else n_pass++;
        @(negedge system_clock);
        set_chans(24'h100000, 24'h100000, 24'h100000, 24'h100000);
        set_regs(8'h77, 8'hFF, 8'h80);
    endtask

    task automatic test_backpressure;
        int   lat;
        logic stable;
        logic [23:0] held_l, held_r;
        out_ready = 1'b0;
        run_mix(lat);
        held_l = out_left;
        held_r = out_right;
        stable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            sample_tick = (c == 3);
            @(negedge system_clock);
            if (out_valid !== 1'b1 || out_left !== held_l || out_right !== held_r) stable = 1'b0;
        end
        sample_tick = 1'b0;
        n_checks++; if (held_l !== 24'h100000) $display("FAIL bp_first_left: got %h want 100000", held_l); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_hold_stable: got %b want 1", stable); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else n_pass++;
        // Accept the held pair and tick on the same edge.
        set_chans(24'h080000, 24'h080000, 24'h080000, 24'h080000);
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        @(negedge system_clock);
        sample_tick = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_accept_drop: got valid %b want 0", out_valid); else n_pass++;
        lat = 1;
        wait_valid(lat);
        n_checks++; if (lat != 6) $display("FAIL bp_retick_latency: got %0d edges want 6", lat); else n_pass++;
        n_checks++; if (out_left !== 24'sh080000) $display("FAIL bp_retick_left: got %h want 080000", out_left); else n_pass++;
        @(negedge system_clock);
    endtask

    task automatic test_reset_midmix;
        int lat;
        set_chans(24'h100000, 24'h100000, 24'h100000, 24'h100000);
        @(negedge system_clock);
        sample_tick = 1'b1;
        @(negedge system_clock);
        sample_tick = 1'b0;
        @(negedge system_clock);
        reset = 1'b1;
        @(negedge system_clock);
        reset = 1'b0;
        n_checks++; if (out_left  !== 24'sh0) $display("FAIL rst_mid_left: got %h want 000000", out_left);   else n_pass++;
        n_checks++; if (out_valid !== 1'b0)   $display("FAIL rst_mid_valid: got %b want 0", out_valid);      else n_pass++;
        n_checks++; if (overrun   !== 1'b0)   $display("FAIL rst_mid_overrun: got %b want 0", overrun);      else n_pass++;
        run_mix(lat);
        n_checks++; if (lat != 6) $display("FAIL rst_mid_latency: got %0d edges want 6", lat); else n_pass++;
        n_checks++; if (out_right !== 24'sh100000) $display("FAIL rst_mid_right: got %h want 100000", out_right); else n_pass++;
        @(negedge system_clock);
    endtask

    task automatic test_back_to_back;
        logic [23:0] vals [3];
        vals[0] = 24'h010000;
        vals[1] = 24'h020000;
        vals[2] = 24'hFF0000;
        out_ready = 1'b1;
        @(negedge system_clock);
        for (int k = 0; k < 3; k++) begin
            set_chans(vals[k], vals[k], vals[k], vals[k]);
            sample_tick = 1'b1;
            @(negedge system_clock);
            sample_tick = 1'b0;
            repeat (5) @(negedge system_clock);
            n_checks++;
            if (out_valid !== 1'b1 || out_left !== vals[k])
                $display("FAIL b2b_pair%0d: got valid %b left %h want valid 1 left %h", k, out_valid, out_left, vals[k]);
            else n_pass++;
        end
        @(negedge system_clock);
        n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unity();
        test_saturate();
        test_pan_volume();
        test_master_disable();
        test_midmix_write();
        test_backpressure();
        test_reset_midmix();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
